// File: rtl/dilithium_op_sequencer.sv
// Dilithium operation sequencer: issues one core opcode per start, then gates the
// host<->core input and output handshakes to the mode-specific word budgets.
module dilithium_op_sequencer #(
  parameter logic [3:0] OP_KG  = 4'h1,
  parameter logic [3:0] OP_SG  = 4'h2,
  parameter logic [3:0] OP_VF  = 4'h3,
  parameter int         KG_IN  = 8,
  parameter int         KG_OUT = 960,
  parameter int         SG_IN  = 640,
  parameter int         SG_OUT = 605,
  parameter int         VF_IN  = 941,
  parameter int         VF_OUT = 1,
  parameter int         CNT_W  = 16,
  parameter int         WD_W   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] op_out,
  output logic       op_valid_out,
  input  logic       core_op_ready,
  input  logic       host_valid_i,
  output logic       host_ready_o,
  output logic       core_valid_o,
  input  logic       core_ready_i,
  input  logic       core_valid_i,
  output logic       core_ready_o,
  output logic       host_valid_o,
  input  logic       host_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] L_KG_IN  = CNT_W'(KG_IN);
  localparam logic [CNT_W-1:0] L_KG_OUT = CNT_W'(KG_OUT);
  localparam logic [CNT_W-1:0] L_SG_IN  = CNT_W'(SG_IN);
  localparam logic [CNT_W-1:0] L_SG_OUT = CNT_W'(SG_OUT);
  localparam logic [CNT_W-1:0] L_VF_IN  = CNT_W'(VF_IN);
  localparam logic [CNT_W-1:0] L_VF_OUT = CNT_W'(VF_OUT);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_op_valid;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_in_left;
  logic [CNT_W-1:0] r_out_left;
  logic [WD_W-1:0]  r_wd;

  logic             w_mode_ok;
  logic [3:0]       w_ld_op;
  logic [CNT_W-1:0] w_ld_in;
  logic [CNT_W-1:0] w_ld_out;
  logic             w_run;
  logic             w_in_act;
  logic             w_out_act;
  logic             w_in_beat;
  logic             w_out_beat;
  logic [CNT_W-1:0] w_in_next;
  logic [CNT_W-1:0] w_out_next;
  logic             w_wd_clr;
  logic [WD_W-1:0]  w_wd_next;
  logic             w_timeout;

  always_comb begin
    w_mode_ok = 1'b1;
    w_ld_op   = '0;
    w_ld_in   = '0;
    w_ld_out  = '0;
    case (mode)
      2'd0: begin
        w_ld_op  = OP_KG;
        w_ld_in  = L_KG_IN;
        w_ld_out = L_KG_OUT;
      end
      2'd1: begin
        w_ld_op  = OP_SG;
        w_ld_in  = L_SG_IN;
        w_ld_out = L_SG_OUT;
      end
      2'd2: begin
        w_ld_op  = OP_VF;
        w_ld_in  = L_VF_IN;
        w_ld_out = L_VF_OUT;
      end
      default: w_mode_ok = 1'b0;
    endcase
  end

  // Zero-latency gates: an exhausted budget closes its stream in both directions.
  assign w_run     = (r_state == S_RUN);
  assign w_in_act  = w_run && (r_in_left != '0);
  assign w_out_act = w_run && (r_out_left != '0);

  assign core_valid_o = host_valid_i & w_in_act;
  assign host_ready_o = core_ready_i & w_in_act;
  assign host_valid_o = core_valid_i & w_out_act;
  assign core_ready_o = host_ready_i & w_out_act;

  assign w_in_beat  = host_valid_i & core_ready_i & w_in_act;
  assign w_out_beat = core_valid_i & host_ready_i & w_out_act;
  assign w_in_next  = r_in_left - CNT_W'(w_in_beat);
  assign w_out_next = r_out_left - CNT_W'(w_out_beat);

  // The watchdog counts the current cycle too, so an activity cycle leaves it at 1.
  assign w_wd_clr  = w_in_beat | w_out_beat | ((r_state == S_ISSUE) & core_op_ready);
  assign w_wd_next = (w_wd_clr ? '0 : r_wd) + WD_W'(1);
  assign w_timeout = &w_wd_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_op_valid <= 1'b0;
      r_op       <= '0;
      r_in_left  <= '0;
      r_out_left <= '0;
      r_wd       <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_mode_ok) begin
              r_state    <= S_ISSUE;
              r_busy     <= 1'b1;
              r_op_valid <= 1'b1;
              r_op       <= w_ld_op;
              r_in_left  <= w_ld_in;
              r_out_left <= w_ld_out;
              r_wd       <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_wd <= w_wd_next;
          if (core_op_ready) begin
            r_op_valid <= 1'b0;
            r_state    <= S_RUN;
          end else if (w_timeout) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_op_valid <= 1'b0;
            r_op       <= '0;
            r_in_left  <= '0;
            r_out_left <= '0;
            r_wd       <= '0;
          end
        end
        S_RUN: begin
          r_in_left  <= w_in_next;
          r_out_left <= w_out_next;
          r_wd       <= w_wd_next;
          // Completion looks at the post-beat counts so done follows the last beat directly.
          if ((w_in_next == '0) && (w_out_next == '0)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_op       <= '0;
            r_in_left  <= '0;
            r_out_left <= '0;
            r_wd       <= '0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_op    <= '0;
          r_wd    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign op_out       = r_op;
  assign op_valid_out = r_op_valid;

endmodule

// File: tb/tb_dilithium_op_sequencer.sv
// Directed bench for dilithium_op_sequencer: small keygen/sign budgets and a
// 4-bit watchdog so every scenario, including the timeout, finishes quickly.
module tb_dilithium_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic       busy, done, err;
  logic [3:0] op_out;
  logic       op_valid_out;
  logic       core_op_ready;
  logic       host_valid_i, host_ready_o;
  logic       core_valid_o, core_ready_i;
  logic       core_valid_i, core_ready_o;
  logic       host_valid_o, host_ready_i;

  int checks = 0;
  int errors = 0;

  int cyc, n_op, n_opv, n_opbad, n_in, n_out, n_gatebad, n_done, n_err;
  int last_beat, last_out, done_cyc, err_cyc;
  logic [3:0] exp_op;

  dilithium_op_sequencer #(
    .KG_IN (4),
    .KG_OUT(6),
    .SG_IN (12),
    .SG_OUT(9),
    .WD_W  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .op_out       (op_out),
    .op_valid_out (op_valid_out),
    .core_op_ready(core_op_ready),
    .host_valid_i (host_valid_i),
    .host_ready_o (host_ready_o),
    .core_valid_o (core_valid_o),
    .core_ready_i (core_ready_i),
    .core_valid_i (core_valid_i),
    .core_ready_o (core_ready_o),
    .host_valid_o (host_valid_o),
    .host_ready_i (host_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_hs(input logic hv, input logic cr, input logic cv, input logic hr);
    host_valid_i = hv;
    core_ready_i = cr;
    core_valid_i = cv;
    host_ready_i = hr;
  endtask

  task automatic clear_counts(input logic [3:0] op);
    cyc = 0; n_op = 0; n_opv = 0; n_opbad = 0; n_in = 0; n_out = 0; n_gatebad = 0;
    n_done = 0; n_err = 0; last_beat = -1; last_out = -1; done_cyc = -1; err_cyc = -1;
    exp_op = op;
  endtask

  // Records what happened in the current cycle; beats complete at the next rising edge.
  task automatic observe;
    cyc++;
    if (op_valid_out && core_op_ready) n_op++;
    if (op_valid_out) n_opv++;
    if (op_valid_out && (op_out !== exp_op)) n_opbad++;
    if ((host_valid_i && host_ready_o) !== (core_valid_o && core_ready_i)) n_gatebad++;
    if ((core_valid_i && core_ready_o) !== (host_valid_o && host_ready_i)) n_gatebad++;
    if (host_valid_i && host_ready_o) begin n_in++; last_beat = cyc; end
    if (core_valid_i && core_ready_o) begin n_out++; last_beat = cyc; last_out = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (err) begin n_err++; err_cyc = cyc; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; core_op_ready = 1'b1;
    set_hs(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if ({busy, done, err, op_valid_out, host_ready_o, core_valid_o, host_valid_o, core_ready_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {busy, done, err, op_valid_out, host_ready_o, core_valid_o, host_valid_o, core_ready_o});
    end
    checks++;
    if (op_out !== 4'h0) begin errors++; $display("FAIL reset_op_out: got %h required 0", op_out); end
    tick; tick;
    rst_n = 1'b1;
    tick;
    checks++;
    if ({busy, host_ready_o, core_ready_o} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got %b required 000", {busy, host_ready_o, core_ready_o});
    end
  endtask

  task automatic test_keygen;
    logic held_checked;
    held_checked = 1'b0;
    clear_counts(4'h1);
    set_hs(1'b1, 1'b1, 1'b1, 1'b1);
    core_op_ready = 1'b1;
    start = 1'b1; mode = 2'd0;
    tick;
    start = 1'b0;
    #1;
    checks++;
    if ({busy, op_valid_out, host_ready_o, host_valid_o} !== 4'b1100) begin
      errors++; $display("FAIL kg_issue_cycle: got %b required 1100", {busy, op_valid_out, host_ready_o, host_valid_o});
    end
    checks++;
    if (op_out !== 4'h1) begin errors++; $display("FAIL kg_opcode: got %h required 1", op_out); end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!held_checked && n_in == 4 && n_out < 6) begin
        held_checked = 1'b1;
        checks++;
        if ({host_ready_o, core_valid_o} !== 2'b00) begin
          errors++; $display("FAIL kg_fifth_input_held: got %b required 00", {host_ready_o, core_valid_o});
        end
      end
      observe;
      tick;
    end
    checks++;
    if (held_checked !== 1'b1) begin errors++; $display("FAIL kg_reached_exhausted_input: got 0 required 1"); end
    checks++;
    if (n_in !== 4) begin errors++; $display("FAIL kg_in_beats: got %0d required 4", n_in); end
    checks++;
    if (n_out !== 6) begin errors++; $display("FAIL kg_out_beats: got %0d required 6", n_out); end
    checks++;
    if (n_op !== 1) begin errors++; $display("FAIL kg_opcode_count: got %0d required 1", n_op); end
    checks++;
    if (n_done !== 1 || done_cyc !== last_out + 1 || last_out !== 7) begin
      errors++; $display("FAIL kg_done_timing: done_cnt %0d done_cyc %0d last_out %0d required 1/8/7", n_done, done_cyc, last_out);
    end
    checks++;
    if (busy !== 1'b0 || n_gatebad !== 0) begin
      errors++; $display("FAIL kg_end_state: busy %b gatebad %0d required 0/0", busy, n_gatebad);
    end
  endtask

  task automatic test_sign_stalls;
    clear_counts(4'h2);
    set_hs(1'b0, 1'b0, 1'b0, 1'b0);
    core_op_ready = 1'b0;
    start = 1'b1; mode = 2'd1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      core_op_ready = (i >= 5);
      set_hs(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      #1;
      observe;
      tick;
    end
    set_hs(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_opv !== 6 || n_opbad !== 0 || n_op !== 1) begin
      errors++; $display("FAIL sg_issue_hold: valid_cycles %0d bad_op %0d accepts %0d required 6/0/1", n_opv, n_opbad, n_op);
    end
    checks++;
    if (n_in !== 12) begin errors++; $display("FAIL sg_in_beats: got %0d required 12", n_in); end
    checks++;
    if (n_out !== 9) begin errors++; $display("FAIL sg_out_beats: got %0d required 9", n_out); end
    checks++;
    if (n_done !== 1 || done_cyc !== last_beat + 1 || n_err !== 0) begin
      errors++; $display("FAIL sg_done_pulse: done_cnt %0d done_cyc %0d last_beat %0d err %0d", n_done, done_cyc, last_beat, n_err);
    end
    checks++;
    if (busy !== 1'b0 || n_gatebad !== 0) begin
      errors++; $display("FAIL sg_end_state: busy %b gatebad %0d required 0/0", busy, n_gatebad);
    end
  endtask

  task automatic test_illegal_mode;
    core_op_ready = 1'b1;
    set_hs(1'b1, 1'b1, 1'b1, 1'b1);
    start = 1'b1; mode = 2'd3;
    tick;
    start = 1'b0; mode = 2'd0;
    #1;
    checks++;
    if ({err, busy, op_valid_out, host_ready_o} !== 4'b1000) begin
      errors++; $display("FAIL illegal_err_cycle: got %b required 1000", {err, busy, op_valid_out, host_ready_o});
    end
    tick;
    checks++;
    if ({err, busy, op_valid_out} !== 3'b000) begin
      errors++; $display("FAIL illegal_after: got %b required 000", {err, busy, op_valid_out});
    end
  endtask

  task automatic test_start_in_run_verify;
    clear_counts(4'h3);
    set_hs(1'b1, 1'b1, 1'b1, 1'b1);
    core_op_ready = 1'b1;
    start = 1'b1; mode = 2'd2;
    tick;
    start = 1'b0;
    for (int i = 0; i < 960; i++) begin
      start = (i >= 10 && i <= 12);
      mode  = (i >= 10 && i <= 12) ? 2'd0 : 2'd2;
      #1;
      observe;
      tick;
    end
    start = 1'b0;
    checks++;
    if (n_op !== 1 || n_opbad !== 0) begin
      errors++; $display("FAIL vf_single_opcode: accepts %0d bad_op %0d required 1/0", n_op, n_opbad);
    end
    checks++;
    if (n_out !== 1 || last_out !== 2) begin
      errors++; $display("FAIL vf_out_beats: got %0d at cycle %0d required 1 at 2", n_out, last_out);
    end
    checks++;
    if (n_in !== 941) begin errors++; $display("FAIL vf_in_beats: got %0d required 941", n_in); end
    checks++;
    if (n_done !== 1 || done_cyc !== last_beat + 1 || done_cyc !== 943) begin
      errors++; $display("FAIL vf_done_timing: done_cnt %0d done_cyc %0d required 1/943", n_done, done_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL vf_end_busy: got %b required 0", busy); end
  endtask

  task automatic test_watchdog;
    clear_counts(4'h1);
    set_hs(1'b1, 1'b1, 1'b0, 1'b1);
    core_op_ready = 1'b1;
    start = 1'b1; mode = 2'd0;
    tick;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      observe;
      tick;
    end
    checks++;
    if (n_in !== 4 || n_out !== 0 || last_beat !== 5) begin
      errors++; $display("FAIL wd_beats: in %0d out %0d last %0d required 4/0/5", n_in, n_out, last_beat);
    end
    checks++;
    if (n_err !== 1 || err_cyc !== last_beat + 15) begin
      errors++; $display("FAIL wd_err_timing: err_cnt %0d err_cyc %0d required 1/%0d", n_err, err_cyc, last_beat + 15);
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL wd_no_done: got %0d required 0", n_done); end
    set_hs(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if ({busy, op_valid_out, host_ready_o, core_valid_o, host_valid_o, core_ready_o} !== 6'b000000) begin
      errors++; $display("FAIL wd_idle_gates: got %b required 000000",
                         {busy, op_valid_out, host_ready_o, core_valid_o, host_valid_o, core_ready_o});
    end
  endtask

  task automatic test_reset_mid_run;
    set_hs(1'b1, 1'b1, 1'b0, 1'b1);
    core_op_ready = 1'b1;
    start = 1'b1; mode = 2'd0;
    tick;
    start = 1'b0;
    tick; tick; tick;
    checks++;
    if ({busy, host_ready_o} !== 2'b11) begin
      errors++; $display("FAIL rst_pre_run: got %b required 11", {busy, host_ready_o});
    end
    set_hs(1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, op_valid_out, host_ready_o, core_valid_o, host_valid_o, core_ready_o, op_out} !== 12'h000) begin
      errors++; $display("FAIL rst_mid_run_outputs: got %b required all zero",
                         {busy, done, err, op_valid_out, host_ready_o, core_valid_o, host_valid_o, core_ready_o, op_out});
    end
    tick;
    rst_n = 1'b1;
    tick;
    clear_counts(4'h1);
    start = 1'b1; mode = 2'd0;
    tick;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      observe;
      tick;
    end
    checks++;
    if (n_in !== 4 || n_out !== 6 || n_done !== 1 || n_op !== 1) begin
      errors++; $display("FAIL rst_full_budget_rerun: in %0d out %0d done %0d op %0d required 4/6/1/1", n_in, n_out, n_done, n_op);
    end
  endtask

  initial begin
    test_reset;
    test_keygen;
    test_sign_stalls;
    test_illegal_mode;
    test_start_in_run_verify;
    test_watchdog;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
